// File: rtl/nn_pkg.sv
// Shared widths, Q9.6 constants and sequencer state encoding for the NN layer datapath.
package nn_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 6;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned MAX_N  = 4;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 3;

  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;
  localparam logic [DATA_W-1:0] Q_ONE = 16'h0040;

  typedef enum logic [2:0] {
    IDLE,
    SWEEP,
    GAP,
    FINAL,
    OUTPUT
  } state_e;

endpackage

// File: rtl/q96_bias_sat.sv
// Rescales a Q-format accumulator to Q9.6, adds a Q9.6 bias and clamps to 16 bits.
module q96_bias_sat
  import nn_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic        [DATA_W-1:0] res_c
);

  logic signed [ACC_W-1:0] sum;

  // Truncating arithmetic shift; overflow shows up as non-uniform bits above the sign bit.
  always_comb begin
    sum = (acc >>> FRAC_W) + ACC_W'(bias);
    if ((sum[ACC_W-1:DATA_W-1] == '0) || (sum[ACC_W-1:DATA_W-1] == '1)) begin
      res_c = sum[DATA_W-1:0];
    end else if (sum[ACC_W-1]) begin
      res_c = Q_MIN;
    end else begin
      res_c = Q_MAX;
    end
  end

endmodule

// File: rtl/layer_mac_sequencer.sv
// Sweeps one layer's weights/biases out of memory, accumulates x*w per neuron and
// streams the biased, saturated Q9.6 neuron results over a valid/ready handshake.
module layer_mac_sequencer
  import nn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       layer_sel,
  input  logic [CNT_W-1:0]       num_in,
  input  logic [CNT_W-1:0]       num_out,
  input  logic [MAX_N*DATA_W-1:0] x_in,
  output logic                   busy,
  output logic                   weight_en,
  output logic                   bias_en,
  output logic [5:0]             n,
  output logic [5:0]             i,
  input  logic [DATA_W-1:0]      wt_data,
  input  logic [DATA_W-1:0]      bias_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   done
);

  state_e                   state;
  logic [IDX_W-1:0]         icnt;
  logic [IDX_W-1:0]         kcnt;
  logic [IDX_W-1:0]         ocnt;
  logic [IDX_W-1:0]         last_in;
  logic [IDX_W-1:0]         last_out;

  logic                     rd_vld;
  logic                     rd_last;
  logic [IDX_W-1:0]         rd_k;
  logic [IDX_W-1:0]         icnt_d;

  logic signed [DATA_W-1:0] x_reg    [MAX_N];
  logic signed [ACC_W-1:0]  acc      [MAX_N];
  logic signed [DATA_W-1:0] bias_reg [MAX_N];
  logic        [DATA_W-1:0] res_c    [MAX_N];
  logic signed [PROD_W-1:0] prod_c;
  logic                     start_ok_c;
  logic [IDX_W-1:0]         icnt_nxt_c;
  logic [IDX_W-1:0]         ocnt_nxt_c;

  assign start_ok_c = start && (num_in  != 3'd0) && (num_in  <= 3'd4)
                            && (num_out != 3'd0) && (num_out <= 3'd4);
  assign icnt_nxt_c = icnt + 2'd1;
  assign ocnt_nxt_c = ocnt + 2'd1;
  assign prod_c     = x_reg[icnt_d] * $signed(wt_data);

  for (genvar g = 0; g < MAX_N; g++) begin : g_sat
    q96_bias_sat u_sat (
      .acc   (acc[g]),
      .bias  (bias_reg[g]),
      .res_c (res_c[g])
    );
  end

  // Sequencer: memory read strobes, result stream and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      weight_en <= 1'b0;
      bias_en   <= 1'b0;
      n         <= '0;
      i         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
      icnt      <= '0;
      kcnt      <= '0;
      ocnt      <= '0;
      last_in   <= '0;
      last_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok_c) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            weight_en <= 1'b1;
            bias_en   <= (num_in == 3'd1);
            n         <= {3'b000, layer_sel};
            i         <= '0;
            icnt      <= '0;
            kcnt      <= '0;
            last_in   <= IDX_W'(num_in - 3'd1);
            last_out  <= IDX_W'(num_out - 3'd1);
          end
        end
        SWEEP: begin
          kcnt <= kcnt + 2'd1;
          if (kcnt == 2'd3) begin
            state     <= GAP;
            weight_en <= 1'b0;
            bias_en   <= 1'b0;
          end
        end
        GAP: begin
          // A low weight_en cycle between sweeps resets the memory's k counter.
          if (icnt != last_in) begin
            state     <= SWEEP;
            weight_en <= 1'b1;
            bias_en   <= (icnt_nxt_c == last_in);
            icnt      <= icnt_nxt_c;
            i         <= {4'b0000, icnt_nxt_c};
          end else begin
            state <= FINAL;
          end
        end
        FINAL: begin
          state     <= OUTPUT;
          out_valid <= 1'b1;
          out_idx   <= '0;
          out_data  <= res_c[0];
          ocnt      <= '0;
        end
        OUTPUT: begin
          if (out_ready) begin
            if (ocnt == last_out) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              ocnt     <= ocnt_nxt_c;
              out_idx  <= ocnt_nxt_c;
              out_data <= res_c[ocnt_nxt_c];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return pipeline: accumulate x*w per neuron, capture biases on the last sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rd_k    <= '0;
      icnt_d  <= '0;
      for (int k = 0; k < MAX_N; k++) begin
        acc[k]      <= '0;
        bias_reg[k] <= '0;
        x_reg[k]    <= '0;
      end
    end else begin
      rd_vld  <= (state == SWEEP);
      rd_last <= (icnt == last_in);
      rd_k    <= kcnt;
      icnt_d  <= icnt;
      if ((state == IDLE) && start_ok_c) begin
        for (int k = 0; k < MAX_N; k++) begin
          x_reg[k] <= x_in[DATA_W*k +: DATA_W];
          acc[k]   <= '0;
        end
      end else if (rd_vld) begin
        acc[rd_k] <= acc[rd_k] + ACC_W'(prod_c);
        if (rd_last) begin
          bias_reg[rd_k] <= bias_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Self-checking bench: behavioural weight/bias memory, arithmetic reference model,
// directed vector table, multi-cycle corner sequences and randomized layers.
module tb_layer_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  layer_sel = '0;
  logic [2:0]  num_in = '0;
  logic [2:0]  num_out = '0;
  logic [63:0] x_in = '0;
  logic        busy, weight_en, bias_en, out_valid, done;
  logic [5:0]  n, i;
  logic [15:0] wt_data = '0;
  logic [15:0] bias_data = '0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_idx;

  int tests = 0;
  int fails = 0;

  logic [15:0] wmem [8][4][4];
  logic [15:0] bmem [8][4];
  logic [1:0]  mk = '0;

  layer_mac_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer_sel (layer_sel),
    .num_in    (num_in),
    .num_out   (num_out),
    .x_in      (x_in),
    .busy      (busy),
    .weight_en (weight_en),
    .bias_en   (bias_en),
    .n         (n),
    .i         (i),
    .wt_data   (wt_data),
    .bias_data (bias_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory: k auto-increments while weight_en is high and clears when it is low.
  always @(posedge clk) begin
    if (weight_en) begin
      wt_data <= wmem[n[2:0]][mk][i[1:0]];
      mk      <= mk + 2'd1;
    end else begin
      mk <= '0;
    end
    if (bias_en) bias_data <= bmem[n[2:0]][mk];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, floor division by 64, bias add, clamp.
  function automatic logic [15:0] model_out(int sel, int nin, int k, logic [63:0] x);
    longint s, q;
    logic [15:0] xv;
    s = 0;
    for (int j = 0; j < nin; j++) begin
      xv = x[16*j +: 16];
      s += longint'($signed(xv)) * longint'($signed(wmem[sel][k][j]));
    end
    q = s / 64;
    if ((s < 0) && ((s % 64) != 0)) q = q - 1;
    q = q + longint'($signed(bmem[sel][k]));
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return 16'(q);
  endfunction

  function automatic logic [63:0] model_vec(int sel, int nin, int nout, logic [63:0] x);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < nout; k++) v[16*k +: 16] = model_out(sel, nin, k, x);
    return v;
  endfunction

  task automatic run_layer(input int sel, input int nin, input int nout, input logic [63:0] x,
                           input logic [63:0] exp, input int stall_in, input int restart_at);
    int cyc, got, lat, p, s, stall;
    bit pat_bad;
    stall = stall_in;
    @(negedge clk);
    layer_sel = 3'(sel); num_in = 3'(nin); num_out = 3'(nout); x_in = x; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_in = {$urandom, $urandom};
    layer_sel = 3'($urandom_range(0, 7));
    num_in = 3'($urandom_range(1, 4));
    num_out = 3'($urandom_range(1, 4));
    cyc = 1; got = 0; lat = 0; pat_bad = 1'b0;
    while (got < nout && cyc < 200) begin
      start = (cyc == restart_at);
      if (cyc <= 5*nin + 1) begin
        p = (cyc - 1) % 5;
        s = (cyc - 1) / 5;
        if (cyc == 5*nin + 1) begin
          if (weight_en || bias_en || out_valid) pat_bad = 1'b1;
        end else begin
          if (weight_en !== (p < 4)) pat_bad = 1'b1;
          if (bias_en !== ((p < 4) && (s == nin - 1))) pat_bad = 1'b1;
          if ((p < 4) && (i !== 6'(s))) pat_bad = 1'b1;
          if (out_valid) pat_bad = 1'b1;
        end
        if ((n !== 6'(sel)) || !busy) pat_bad = 1'b1;
      end
      if (out_valid) begin
        if (lat == 0) lat = cyc;
        check("result", {30'b0, out_idx, 16'b0, out_data}, {30'b0, 2'(got), 16'b0, exp[16*got +: 16]});
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          got++;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (got < nout) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("results_received", 64'(got), 64'(nout));
    check("latency", 64'(lat), 64'(5*nin + 2));
    check("sweep_pattern", 64'(pat_bad), 64'd0);
    if (got == nout) begin
      @(negedge clk);
      check("done_pulse", {61'b0, done, out_valid, busy}, 64'b100);
      out_ready = 1'b0;
      @(negedge clk);
      check("done_clear", {62'b0, done, busy}, 64'b0);
    end
  endtask

  typedef struct {
    int          sel;
    int          nin;
    int          nout;
    logic [63:0] x;
    logic [63:0] exp;
    int          stall;
    int          restart;
  } vec_t;

  vec_t vecs[5];
  logic [2:0] bad_in  [4];
  logic [2:0] bad_out [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] xr;
    int sel, nin, nout;
    bit seen;

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 4; b++) begin
        bmem[a][b] = 16'($urandom_range(0, 2047)) - 16'd1024;
        for (int c = 0; c < 4; c++) wmem[a][b][c] = 16'($urandom_range(0, 511)) - 16'd256;
      end
    wmem[0][0][0] = 16'h0040;
    wmem[0][1][0] = 16'h0080;
    bmem[0][0]    = 16'h0078;
    bmem[0][1]    = 16'h0059;

    vecs[0] = '{0, 1, 2, 64'h0000_0000_0000_0040, 64'h0000_0000_00D9_00B8, 0, -1};
    vecs[1] = '{0, 1, 2, 64'h0000_0000_0000_7FFF, 64'h0000_0000_7FFF_7FFF, 0, -1};
    vecs[2] = '{0, 1, 2, 64'h0000_0000_0000_8000, 64'h0000_0000_8000_8078, 0, -1};
    vecs[3] = '{0, 1, 2, 64'h0000_0000_0000_0040, 64'h0000_0000_00D9_00B8, 3, -1};
    vecs[4] = '{0, 1, 2, 64'hDEAD_BEEF_1234_0040, 64'h0000_0000_00D9_00B8, 0, 2};
    bad_in[0] = 3'd0; bad_out[0] = 3'd2;
    bad_in[1] = 3'd2; bad_out[1] = 3'd0;
    bad_in[2] = 3'd5; bad_out[2] = 3'd1;
    bad_in[3] = 3'd1; bad_out[3] = 3'd7;

    repeat (3) @(negedge clk);
    check("reset_outputs", {29'b0, busy, weight_en, bias_en, out_valid, done, n, i, out_data, out_idx}, 64'b0);
    rst_n = 1'b1;

    // Three-input, four-output layer: sweep waveform, latency and all four neurons.
    xr = {$urandom, $urandom};
    run_layer(0, 3, 4, xr, model_vec(0, 3, 4, xr), 0, -1);

    for (int t = 0; t < 5; t++)
      run_layer(vecs[t].sel, vecs[t].nin, vecs[t].nout, vecs[t].x, vecs[t].exp,
                vecs[t].stall, vecs[t].restart);

    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      num_in = bad_in[t]; num_out = bad_out[t]; layer_sel = 3'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
        seen |= busy | weight_en | done | out_valid;
        @(negedge clk);
      end
      check("illegal_start", 64'(seen), 64'd0);
    end

    // Reset in the middle of the second sweep.
    @(negedge clk);
    layer_sel = 3'd0; num_in = 3'd2; num_out = 3'd2; x_in = 64'h0000_0000_0100_0040; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("second_sweep_active", {62'b0, weight_en, busy}, 64'b11);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {29'b0, busy, weight_en, bias_en, out_valid, done, n, i, out_data, out_idx}, 64'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_layer(vecs[0].sel, vecs[0].nin, vecs[0].nout, vecs[0].x, vecs[0].exp, 0, -1);

    for (int t = 0; t < 20; t++) begin
      sel  = int'($urandom_range(0, 7));
      nin  = int'($urandom_range(1, 4));
      nout = int'($urandom_range(1, 4));
      for (int j = 0; j < 4; j++)
        xr[16*j +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                     : 16'($urandom_range(0, 1023)) - 16'd512;
      run_layer(sel, nin, nout, xr, model_vec(sel, nin, nout, xr),
                int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1) ? 3 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
